// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory/writeback-feed stage.
// Op classification lives here so the stage and any future decode logic agree on it.
package mem_stage_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_REG_W  = 5;
  localparam int LANE_W     = 32;
  localparam int LANES      = DEF_DATA_W / LANE_W;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_PASS    = 2'd0,
    OP_LOAD    = 2'd1,
    OP_STORE   = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  function automatic op_e classify_op(input logic mem_read, input logic mem_write);
    op_e op;
    case ({mem_read, mem_write})
      2'b00:   op = OP_PASS;
      2'b10:   op = OP_LOAD;
      2'b01:   op = OP_STORE;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execution-side handshake, writeback bundle and status/perf outputs of mem_stage.
// master = execution stage / register file side, slave = mem_stage.
interface mem_stage_if #(
  parameter int DATA_W = 128,
  parameter int REG_W  = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_word;

  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_reg_write;

  logic              busy;
  logic              illegal_op;
  logic [31:0]       stall_cycles;
  logic [31:0]       ops_retired;

  modport master (
    output ex_valid, ex_result, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_word,
    input  ex_ready, wb_valid, wb_rd, wb_data, wb_reg_write,
           busy, illegal_op, stall_cycles, ops_retired
  );

  modport slave (
    input  ex_valid, ex_result, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_word,
    output ex_ready, wb_valid, wb_rd, wb_data, wb_reg_write,
           busy, illegal_op, stall_cycles, ops_retired
  );
endinterface

// File: rtl/mem_stage_ram.sv
// Single-port local data RAM: per-32-bit-lane write enables, registered read.
// Read-during-write returns the old entry contents.
module mem_stage_ram
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [DATA_W/LANE_W-1:0]   we_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int NLANES = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int l = 0; l < NLANES; l++) begin
      if (we_i[l]) begin
        mem_q[addr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory/writeback-feed stage: pass-through, load and store ops against a local RAM
// with fixed MEM_LAT occupancy. Perf counters built only when MEM_STAGE_PERF_EN is defined.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam logic [0:0] S_IDLE   = 1'(IDLE);
  localparam logic [0:0] S_ACCESS = 1'(ACCESS);
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic              word_q, word_d;
  logic              store_q, store_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              illegal_q, illegal_d;

  op_e               op;
  logic              ex_ready;
  logic              accept;
  logic [ADDR_W-1:0] ram_addr;
  logic [NLANES-1:0] ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [LANE_W-1:0] lane_word;
  logic              unused_result_hi;

  assign op        = classify_op(bus.ex_mem_read, bus.ex_mem_write);
  assign ex_ready  = (state_q == S_IDLE);
  assign accept    = bus.ex_valid && ex_ready;
  assign lane_word = ram_rdata[lane_q*LANE_W +: LANE_W];
  assign ram_wdata = word_q ? {NLANES{sdata_q[LANE_W-1:0]}} : sdata_q;
  assign unused_result_hi = ^bus.ex_result[DATA_W-1:ADDR_W+2];

  // In IDLE the RAM is addressed straight from ex_result so the read is
  // already registered when the op enters ACCESS, which keeps MEM_LAT=1 legal.
  assign ram_addr = (state_q == S_ACCESS) ? addr_q : bus.ex_result[ADDR_W+1:2];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    lane_d         = lane_q;
    word_d         = word_q;
    store_d        = store_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    sdata_d        = sdata_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_reg_write_d = 1'b0;
    illegal_d      = illegal_q;
    ram_we         = '0;

    if (state_q == S_IDLE) begin
      if (accept) begin
        case (op)
          OP_PASS: begin
            wb_valid_d     = 1'b1;
            wb_data_d      = bus.ex_result;
            wb_rd_d        = bus.ex_rd;
            wb_reg_write_d = bus.ex_reg_write;
          end
          OP_LOAD, OP_STORE: begin
            state_d     = S_ACCESS;
            cnt_d       = CNT_INIT;
            addr_d      = bus.ex_result[ADDR_W+1:2];
            lane_d      = bus.ex_result[1:0];
            word_d      = bus.ex_word;
            store_d     = (op == OP_STORE);
            rd_d        = bus.ex_rd;
            reg_write_d = bus.ex_reg_write;
            sdata_d     = bus.ex_store_data;
          end
          default: illegal_d = 1'b1;
        endcase
      end
    end else begin
      if (cnt_q == 4'd0) begin
        state_d = S_IDLE;
        if (store_q) begin
          ram_we = word_q ? (NLANES'(1) << lane_q) : {NLANES{1'b1}};
        end else begin
          wb_valid_d     = 1'b1;
          wb_data_d      = word_q ? DATA_W'(lane_word) : ram_rdata;
          wb_rd_d        = rd_q;
          wb_reg_write_d = reg_write_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      lane_q         <= '0;
      word_q         <= 1'b0;
      store_q        <= 1'b0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      sdata_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_reg_write_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      lane_q         <= lane_d;
      word_q         <= word_d;
      store_q        <= store_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      sdata_q        <= sdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_reg_write_q <= wb_reg_write_d;
      illegal_q      <= illegal_d;
    end
  end

  mem_stage_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] stall_q, ops_q;

  // Both counters saturate rather than wrap so long runs never read back small.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      ops_q   <= '0;
    end else begin
      if (bus.ex_valid && !ex_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (accept && (op != OP_ILLEGAL) && (ops_q != '1)) begin
        ops_q <= ops_q + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.ops_retired  = ops_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.ops_retired  = '0;
`endif

  assign bus.ex_ready     = ex_ready;
  assign bus.busy         = (state_q == S_ACCESS);
  assign bus.illegal_op   = illegal_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_reg_write = wb_reg_write_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory/writeback-feed stage directly downstream of the execution stage in the crypto accelerator datapath.
- Consumes the 128-bit execution result plus control, and performs loads and stores against a local 128-bit-wide data RAM with fixed multi-cycle latency.
- Presents a registered writeback bundle to the register file.
- Stalls upstream via a valid/ready handshake while a memory access is in flight.

Parameters:
- DATA_W, 128, datapath width.
- ADDR_W, 8, RAM entry index width; depth = 2**ADDR_W entries of DATA_W bits.
- REG_W, 5, destination register index width.
- MEM_LAT, 2, memory access occupancy in cycles; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execution stage presents an op.
- ex_ready  out  1  stage accepts the op this cycle.
- ex_result  in  DATA_W  ALU result; for memory ops, bits [ADDR_W+1:2] are the entry index and [1:0] the 32-bit lane.
- ex_store_data  in  DATA_W  store data.
- ex_rd  in  REG_W  destination register.
- ex_reg_write  in  1  op writes the register file.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_word  in  1  1 = 32-bit lane access, 0 = full 128-bit access.
- wb_valid  out  1  writeback bundle valid, one-cycle pulse.
- wb_rd  out  REG_W  writeback register.
- wb_data  out  DATA_W  writeback data.
- wb_reg_write  out  1  register-file write enable.
- busy  out  1  memory access in flight.
- illegal_op  out  1  sticky error flag.
- stall_cycles  out  32  perf counter; see Optional Feature.
- ops_retired  out  32  perf counter; see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter 0, all outputs 0. RAM contents are not reset.
- Handshake: an op is accepted at a rising edge where ex_valid && ex_ready. ex_ready = (state==IDLE). ex_ready does not depend on ex_valid.
- FSM states: IDLE, ACCESS.
- Pass-through op (mem_read=0, mem_write=0):
  - Accepted in IDLE; state stays IDLE.
  - Next cycle: wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_reg_write=ex_reg_write.
  - Throughput 1 op/cycle.
- Load:
  - IDLE -> ACCESS; counter loaded with MEM_LAT-1; address and rd latched.
  - In ACCESS the counter decrements each cycle. At the edge where the counter is 0: RAM read data is captured, state -> IDLE, and wb_valid is asserted the following cycle.
  - Load accepted at edge N gives wb_valid high in the cycle after edge N+MEM_LAT.
  - ex_ready is low for exactly MEM_LAT cycles and is high again in the wb_valid cycle.
  - Full access: wb_data = entry.
  - Word access: wb_data = zero-extended lane[lane*32 +: 32].
- Store:
  - Same occupancy as a load.
  - RAM written at the edge leaving ACCESS.
  - Full access writes the whole entry with ex_store_data. Word access writes only the selected lane with ex_store_data[31:0].
  - No wb_valid is produced.
- mem_read && mem_write together:
  - Illegal. Consumed in 1 cycle as a no-op: no RAM access, no wb_valid.
  - illegal_op set; it stays set until reset.
- busy = (state==ACCESS).
- wb_valid deasserts the cycle after its pulse unless a new pass-through op retires.
- Back-to-back: a load followed by a dependent load sees RAM order preserved, because only one access is ever outstanding.
- Store then load to the same entry: the load returns the stored value.
- ex_result bits above ADDR_W+1 are ignored; no out-of-range condition exists.
- Reset during ACCESS: the access is aborted. A pending store is not written and no wb_valid is produced.

Optional Feature:
- Macro: MEM_STAGE_PERF_EN.
- Defined:
  - stall_cycles counts cycles with ex_valid=1 && ex_ready=0.
  - ops_retired counts accepted legal ops.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum {IDLE, ACCESS};
  - LANE_W=32;
  - LANES=DATA_W/LANE_W;
  - op-class enum {OP_PASS, OP_LOAD, OP_STORE, OP_ILLEGAL}.
- Sub-module mem_stage_ram:
  - synchronous single-port RAM, 2**ADDR_W x DATA_W;
  - per-lane write enables;
  - registered read.

Test Plan:
- Reset mid-store: assert reset during ACCESS of a store 0xAA.. to entry 5 -> outputs 0, state IDLE; a subsequent load of entry 5 does not return 0xAA.. (it reads the prior value).
- Pass-through burst: 4 ops, ex_result 0x1..0x4, rd 1..4 -> wb_valid on 4 consecutive cycles, data 0x1..0x4, ex_ready held 1.
- Full store/load: store 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D to entry 3, then load entry 3 to rd 7 -> with MEM_LAT=2, wb_valid 2 cycles after load acceptance, wb_data equals the stored value, wb_rd=7.
- Word lane: full store of 0 to entry 9, word store 0x12345678 to lane 2, full load -> wb_data = 0x00000000_12345678_00000000_00000000. Word load of lane 2 -> 0x12345678 zero-extended.
- Stall accounting (MEM_STAGE_PERF_EN): ex_valid held high with a load then a pass-through, MEM_LAT=3 -> ex_ready low 3 cycles, stall_cycles=3, ops_retired=2.
- Illegal op: mem_read=mem_write=1 -> no wb_valid, ex_ready stays 1, illegal_op=1 until reset.
